// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Round-robin, non-preemptive sharing of one single-port RAM
//            between cache line bursts and a single-word user port.
// Revision : 1.0
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W    = 13,
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cache_req_i,
  input  logic              cache_we_i,
  input  logic [ADDR_W-1:0] cache_addr_i,
  input  logic [DATA_W-1:0] cache_wdata_i,
  output logic              cache_wnext_o,
  output logic              cache_rvalid_o,
  output logic [DATA_W-1:0] cache_rdata_o,
  output logic              cache_done_o,
  input  logic              user_req_i,
  input  logic              user_we_i,
  input  logic [ADDR_W-1:0] user_addr_i,
  input  logic [DATA_W-1:0] user_din_i,
  output logic [DATA_W-1:0] user_dout_o,
  output logic              user_ack_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_din_o,
  input  logic [DATA_W-1:0] mem_dout_i,
  output logic              busy_o
);

  localparam int              BEAT_W    = $clog2(BURST_LEN);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    C_WR    = 3'd1,
    C_RD    = 3'd2,
    C_DRAIN = 3'd3,
    U_ACC   = 3'd4,
    U_WAIT  = 3'd5
  } state_t;

  state_t                     state_q;
  logic [BEAT_W-1:0]          beat_q;
  logic [BEAT_W-1:0]          beat_d;
  logic [ADDR_W-BEAT_W-1:0]   line_q;
  logic [DATA_W-1:0]          udin_q;
  logic [DATA_W-1:0]          user_dout_q;
  logic                       uwe_q;
  logic                       last_cache_q;
  logic                       mem_en_q;
  logic                       mem_we_q;
  logic [ADDR_W-1:0]          mem_addr_q;
  logic                       wnext_q;
  logic                       rvalid_q;
  logic                       done_q;
  logic                       ack_q;
  logic                       grant_cache;
  logic                       grant_user;
  logic                       unused_line_offset;

  assign beat_d             = beat_q + 1'b1;
  assign grant_cache        = cache_req_i && (!user_req_i || !last_cache_q);
  assign grant_user         = user_req_i && !grant_cache;
  assign unused_line_offset = ^cache_addr_i[BEAT_W-1:0];

  // Outputs for cycle N+1 are registered at the edge that enters that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      line_q       <= '0;
      udin_q       <= '0;
      uwe_q        <= 1'b0;
      last_cache_q <= 1'b0;
      user_dout_q  <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      wnext_q      <= 1'b0;
      rvalid_q     <= 1'b0;
      done_q       <= 1'b0;
      ack_q        <= 1'b0;
    end else begin
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      wnext_q    <= 1'b0;
      rvalid_q   <= 1'b0;
      done_q     <= 1'b0;
      ack_q      <= 1'b0;
      unique case (state_q)
        IDLE: begin
          beat_q <= '0;
          if (grant_cache) begin
            last_cache_q <= 1'b1;
            line_q       <= cache_addr_i[ADDR_W-1:BEAT_W];
            mem_en_q     <= 1'b1;
            mem_we_q     <= cache_we_i;
            mem_addr_q   <= {cache_addr_i[ADDR_W-1:BEAT_W], {BEAT_W{1'b0}}};
            wnext_q      <= cache_we_i;
            state_q      <= cache_we_i ? C_WR : C_RD;
          end else if (grant_user) begin
            last_cache_q <= 1'b0;
            uwe_q        <= user_we_i;
            udin_q       <= user_din_i;
            mem_en_q     <= 1'b1;
            mem_we_q     <= user_we_i;
            mem_addr_q   <= user_addr_i;
            state_q      <= U_ACC;
          end
        end
        C_WR: begin
          if (beat_q == LAST_BEAT) begin
            beat_q  <= '0;
            state_q <= IDLE;
          end else begin
            beat_q     <= beat_d;
            mem_en_q   <= 1'b1;
            mem_we_q   <= 1'b1;
            mem_addr_q <= {line_q, beat_d};
            wnext_q    <= 1'b1;
            done_q     <= (beat_d == LAST_BEAT);
          end
        end
        C_RD: begin
          // Every issued read returns one cycle later, including the last one.
          rvalid_q <= 1'b1;
          if (beat_q == LAST_BEAT) begin
            done_q  <= 1'b1;
            state_q <= C_DRAIN;
          end else begin
            beat_q     <= beat_d;
            mem_en_q   <= 1'b1;
            mem_addr_q <= {line_q, beat_d};
          end
        end
        C_DRAIN: begin
          beat_q  <= '0;
          state_q <= IDLE;
        end
        U_ACC: begin
          ack_q   <= 1'b1;
          state_q <= U_WAIT;
        end
        U_WAIT: begin
          if (!uwe_q) begin
            user_dout_q <= mem_dout_i;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_en_o       = mem_en_q;
  assign mem_we_o       = mem_we_q;
  assign mem_addr_o     = mem_addr_q;
  assign mem_din_o      = (state_q == C_WR)  ? cache_wdata_i :
                          (state_q == U_ACC) ? udin_q : '0;
  assign cache_wnext_o  = wnext_q;
  assign cache_rvalid_o = rvalid_q;
  assign cache_rdata_o  = rvalid_q ? mem_dout_i : '0;
  assign cache_done_o   = done_q;
  assign user_dout_o    = user_dout_q;
  assign user_ack_o     = ack_q;
  assign busy_o         = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Table of user accesses, directed burst/arbitration/reset cases
//            and random traffic against a transaction-level memory model.
// Revision : 1.0
// ============================================================================
module tb_mem_port_arbiter;

  localparam int AW = 13;
  localparam int DW = 32;
  localparam int BL = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cache_req, cache_we, cache_wnext, cache_rvalid, cache_done;
  logic [AW-1:0] cache_addr;
  logic [DW-1:0] cache_wdata, cache_rdata;
  logic          user_req, user_we, user_ack;
  logic [AW-1:0] user_addr;
  logic [DW-1:0] user_din, user_dout;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  bit   [DW-1:0] mem_dout;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst),
    .cache_req_i(cache_req), .cache_we_i(cache_we), .cache_addr_i(cache_addr),
    .cache_wdata_i(cache_wdata), .cache_wnext_o(cache_wnext), .cache_rvalid_o(cache_rvalid),
    .cache_rdata_o(cache_rdata), .cache_done_o(cache_done),
    .user_req_i(user_req), .user_we_i(user_we), .user_addr_i(user_addr), .user_din_i(user_din),
    .user_dout_o(user_dout), .user_ack_o(user_ack),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_din_o(mem_din),
    .mem_dout_i(mem_dout), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM with one-cycle read latency.
  bit [DW-1:0] ram    [0:(1<<AW)-1];
  bit [DW-1:0] shadow [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_din;
      else        mem_dout      <= ram[mem_addr];
    end
  end

  int total = 0;
  int bad   = 0;

  // Requester agents
  bit          c_pend, c_we, c_gapless, u_pend, u_we, u_gapless;
  bit [AW-1:0] c_addr, u_addr;
  bit [DW-1:0] c_words [BL];
  bit [DW-1:0] rd_buf  [BL];
  bit [DW-1:0] u_din;
  int          c_left, u_left;

  // Transaction-level reference state
  bit          last_c, pred_new, chk_ud;
  int          pend_kind;   // 0 none, 1 cache, 2 user
  int          tr_cyc, wn_cnt, rv_cnt, cyc, last_done_cyc, ack_gap;
  bit [DW-1:0] ud_model;
  logic [15:0] order;
  int          norder;

  typedef struct {
    bit          we;
    bit [AW-1:0] addr;
    bit [DW-1:0] din;
    bit [DW-1:0] exp_dout;
  } uvec_t;
  uvec_t tbl [10];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive();
    int idx;
    idx = wn_cnt - ((cache_wnext === 1'b1) ? 1 : 0);
    if (idx > BL - 1) idx = BL - 1;
    if (idx < 0) idx = 0;
    cache_req   = c_pend;
    cache_we    = c_we;
    cache_addr  = c_addr;
    cache_wdata = c_words[idx];
    user_req    = u_pend;
    user_we     = u_we;
    user_addr   = u_addr;
    user_din    = u_din;
  endtask

  task automatic new_cache_txn();
    c_we   = 1'($urandom_range(0, 1));
    c_addr = AW'(32'h100 + $urandom_range(0, 63));
    foreach (c_words[k]) c_words[k] = $urandom;
    c_pend = 1'b1;
  endtask

  task automatic new_user_txn();
    u_we   = 1'($urandom_range(0, 1));
    u_addr = AW'(32'h100 + $urandom_range(0, 63));
    u_din  = $urandom;
    u_pend = 1'b1;
  endtask

  // One clock cycle: observe settled outputs at the falling edge, update the
  // model, then present the inputs sampled at the next rising edge.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (pred_new) begin
      check("grant_started", busy, 1'b1);
      pred_new = 1'b0;
    end
    if (busy) tr_cyc++;
    check("we_without_en", mem_we & ~mem_en, 1'b0);
    if (chk_ud) begin
      check("user_dout_model", user_dout, ud_model);
      chk_ud = 1'b0;
    end
    if (cache_wnext) wn_cnt++;
    if (cache_rvalid) begin
      if (rv_cnt < BL) begin
        rd_buf[rv_cnt] = cache_rdata;
        check("refill_word", cache_rdata, shadow[{c_addr[AW-1:3], 3'(rv_cnt)}]);
      end
      rv_cnt++;
    end
    if (cache_done) begin
      check("done_owner", pend_kind, 1);
      check("cache_latency", tr_cyc, c_we ? BL : BL + 1);
      if (c_we) begin
        check("wnext_beats", wn_cnt, BL);
        for (int k = 0; k < BL; k++) shadow[{c_addr[AW-1:3], 3'(k)}] = c_words[k];
      end else begin
        check("rvalid_beats", rv_cnt, BL);
      end
      order = {order[14:0], 1'b1};
      norder++;
      last_done_cyc = cyc;
      c_pend = 1'b0;
      pend_kind = 0;
    end
    if (user_ack) begin
      check("ack_owner", pend_kind, 2);
      check("user_latency", tr_cyc, 2);
      if (u_we) shadow[u_addr] = u_din;
      else      ud_model = shadow[u_addr];
      chk_ud  = 1'b1;
      order   = {order[14:0], 1'b0};
      norder++;
      ack_gap = cyc - last_done_cyc;
      u_pend  = 1'b0;
      pend_kind = 0;
    end
    if (!busy && !c_pend && c_left > 0 && (c_gapless || $urandom_range(0, 2) == 0)) begin
      new_cache_txn();
      c_left--;
    end
    if (!busy && !u_pend && u_left > 0 && (u_gapless || $urandom_range(0, 2) == 0)) begin
      new_user_txn();
      u_left--;
    end
    if (!busy && (c_pend || u_pend)) begin
      pend_kind = (c_pend && (!u_pend || !last_c)) ? 1 : 2;
      last_c    = (pend_kind == 1);
      pred_new  = 1'b1;
      tr_cyc    = 0;
      wn_cnt    = 0;
      rv_cnt    = 0;
    end
    drive();
  endtask

  task automatic run_until_quiet(input int maxc, input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while ((c_pend || u_pend || c_left > 0 || u_left > 0 || busy) && n < maxc);
    if (c_pend || u_pend || c_left > 0 || u_left > 0 || busy) begin
      total++;
      bad++;
      $display("FAIL timeout_%s: still active after %0d cycles, required idle", tag, maxc);
    end
  endtask

  task automatic apply_reset();
    rst    = 1'b1;
    c_pend = 1'b0;
    u_pend = 1'b0;
    c_left = 0;
    u_left = 0;
    drive();
    @(negedge clk);
    check("reset_outputs",
          {mem_en, mem_we, mem_addr, mem_din, cache_wnext, cache_rvalid, cache_rdata,
           cache_done, user_dout, user_ack, busy}, '0);
    rst       = 1'b0;
    last_c    = 1'b0;
    pend_kind = 0;
    pred_new  = 1'b0;
    chk_ud    = 1'b0;
    ud_model  = '0;
    wn_cnt    = 0;
    rv_cnt    = 0;
    tr_cyc    = 0;
  endtask

  initial begin
    bit found;
    int nmis;

    tbl[0] = '{1'b1, 13'h0005, 32'd37,        32'd0};
    tbl[1] = '{1'b0, 13'h0005, 32'd0,         32'd37};
    tbl[2] = '{1'b1, 13'h001B, 32'h0000_0A1B, 32'd37};
    tbl[3] = '{1'b1, 13'h001C, 32'h0000_0A1C, 32'd37};
    tbl[4] = '{1'b1, 13'h001F, 32'h0000_0A1F, 32'd37};
    tbl[5] = '{1'b0, 13'h001B, 32'd0,         32'h0000_0A1B};
    tbl[6] = '{1'b0, 13'h0000, 32'd0,         32'd0};
    tbl[7] = '{1'b1, 13'h1FFF, 32'hDEAD_BEEF, 32'd0};
    tbl[8] = '{1'b0, 13'h1FFF, 32'd0,         32'hDEAD_BEEF};
    tbl[9] = '{1'b0, 13'h0005, 32'd0,         32'd37};

    c_gapless = 1'b1;
    u_gapless = 1'b1;
    order     = '0;
    norder    = 0;
    apply_reset();

    // Single-word user accesses
    foreach (tbl[i]) begin
      u_we   = tbl[i].we;
      u_addr = tbl[i].addr;
      u_din  = tbl[i].din;
      u_pend = 1'b1;
      run_until_quiet(20, "table");
      check("table_user_dout", user_dout, tbl[i].exp_dout);
    end

    // Writeback line 0x010 with words 1..8
    c_we   = 1'b1;
    c_addr = 13'h010;
    foreach (c_words[k]) c_words[k] = DW'(k + 1);
    c_pend = 1'b1;
    run_until_quiet(30, "writeback");
    for (int k = 0; k < BL; k++) check("wb_ram_word", ram[13'h010 + k], DW'(k + 1));

    // Refill through a misaligned address inside the same line
    c_we   = 1'b0;
    c_addr = 13'h013;
    c_pend = 1'b1;
    run_until_quiet(30, "refill");
    check("refill_count", rv_cnt, BL);
    for (int k = 0; k < BL; k++) check("refill_const", rd_buf[k], DW'(k + 1));

    // Reset in the middle of a writeback to line 0x018
    c_we   = 1'b1;
    c_addr = 13'h018;
    foreach (c_words[k]) c_words[k] = 32'hB000_0000 + DW'(k);
    c_pend = 1'b1;
    found  = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      step();
      if (cache_wnext && mem_addr == 13'h01A) found = 1'b1;
    end
    check("abort_reached_beat", found, 1'b1);
    apply_reset();
    repeat (10) step();
    for (int a = 'h1B; a <= 'h1F; a++) check("abort_ram_untouched", ram[a], shadow[a]);

    // Simultaneous requests from reset, cache re-requesting immediately
    apply_reset();
    order  = '0;
    norder = 0;
    c_left = 2;
    u_left = 1;
    run_until_quiet(100, "simul");
    check("simul_count", norder, 3);
    check("simul_order", order[2:0], 3'b101);
    check("simul_ack_gap", ack_gap, 3);

    // Both requesters saturating: strict alternation over ten transactions
    apply_reset();
    order  = '0;
    norder = 0;
    c_left = 5;
    u_left = 5;
    run_until_quiet(200, "alternate");
    check("alt_count", norder, 10);
    check("alt_order", order[9:0], 10'b10_1010_1010);

    // Random traffic with gaps on a shared address window
    apply_reset();
    c_gapless = 1'b0;
    u_gapless = 1'b0;
    c_left    = 40;
    u_left    = 60;
    run_until_quiet(5000, "random");
    nmis = 0;
    for (int a = 'h100; a < 'h140; a++) if (ram[a] != shadow[a]) nmis++;
    check("random_ram_mismatches", nmis, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
